// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared write-back constants: data/address widths, hardwired-zero register, source indices.
package regfile_wb_arbiter_pkg;
  localparam int WORD              = 32;
  localparam int REG_ADDRESS_SPACE = 5;
  localparam logic [REG_ADDRESS_SPACE-1:0] ZERO_REGISTER = 5'b00000;
  localparam logic SRC_ALU  = 1'b0;
  localparam logic SRC_LOAD = 1'b1;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester grant logic: round-robin (PRIORITY_MODE=0) or fixed src0 priority (1).
// Latency: grants combinational, last_grant registered. Backpressure: loser simply sees gnt=0.
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic last_grant
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0 && req1) begin
        // Under contention round-robin hands the grant to whoever lost last time.
        if (PRIORITY_MODE == 1 || last_grant == SRC_LOAD) gnt0 = 1'b1;
        else                                               gnt1 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    last_grant <= SRC_LOAD;
    else if (gnt0) last_grant <= SRC_ALU;
    else if (gnt1) last_grant <= SRC_LOAD;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU (src0) and load unit (src1); optional read bypass under WB_ARB_BYPASS_EN.
// Latency: handshake at cycle t drives wr_en/wr_addr/wr_data at t+1. Backpressure: output never stalls, ready == grant.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int WIDTH         = WORD,
  parameter int ADDR_SPACE    = REG_ADDRESS_SPACE,
  parameter logic [ADDR_SPACE-1:0] ZERO_REGISTER = regfile_wb_arbiter_pkg::ZERO_REGISTER,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src0_valid,
  input  logic [ADDR_SPACE-1:0] src0_addr,
  input  logic [WIDTH-1:0]      src0_data,
  output logic                  src0_ready,
  input  logic                  src1_valid,
  input  logic [ADDR_SPACE-1:0] src1_addr,
  input  logic [WIDTH-1:0]      src1_data,
  output logic                  src1_ready,
  output logic                  wr_en,
  output logic [ADDR_SPACE-1:0] wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  last_grant
`ifdef WB_ARB_BYPASS_EN
  ,
  input  logic [ADDR_SPACE-1:0] rd1_addr,
  input  logic [ADDR_SPACE-1:0] rd2_addr,
  input  logic [WIDTH-1:0]      rf_r1_data,
  input  logic [WIDTH-1:0]      rf_r2_data,
  output logic [WIDTH-1:0]      byp_r1_data,
  output logic [WIDTH-1:0]      byp_r2_data
`endif
);

  logic                  gnt0;
  logic                  gnt1;
  logic [ADDR_SPACE-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_data;

  rr_arb2 #(.PRIORITY_MODE(PRIORITY_MODE)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (src0_valid),
    .req1       (src1_valid),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .last_grant (last_grant)
  );

  assign src0_ready = gnt0;
  assign src1_ready = gnt1;
  assign sel_addr   = gnt1 ? src1_addr : src0_addr;
  assign sel_data   = gnt1 ? src1_data : src0_data;

  // Zero-register writes complete the handshake but are suppressed at the port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (gnt0 || gnt1) begin
      wr_en   <= (sel_addr != ZERO_REGISTER);
      wr_addr <= sel_addr;
      wr_data <= sel_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

`ifdef WB_ARB_BYPASS_EN
  // Covers the cycle between the staged write and the register file actually updating.
  assign byp_r1_data = (wr_en && wr_addr == rd1_addr && rd1_addr != ZERO_REGISTER) ? wr_data : rf_r1_data;
  assign byp_r2_data = (wr_en && wr_addr == rd2_addr && rd2_addr != ZERO_REGISTER) ? wr_data : rf_r2_data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: round-robin instance (dut) and fixed-priority instance (dut_p) share one stimulus stream.
module tb_regfile_wb_arbiter;
  localparam int W = 32;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         src0_valid, src1_valid;
  logic [A-1:0] src0_addr, src1_addr;
  logic [W-1:0] src0_data, src1_data;

  logic         r0_ready, r1_ready, r_en, r_lg;
  logic [A-1:0] r_addr;
  logic [W-1:0] r_data;
  logic         p0_ready, p1_ready, p_en, p_lg;
  logic [A-1:0] p_addr;
  logic [W-1:0] p_data;

`ifdef WB_ARB_BYPASS_EN
  logic [A-1:0] rd1_addr, rd2_addr;
  logic [W-1:0] rf_r1_data, rf_r2_data;
  logic [W-1:0] byp1, byp2, pbyp1, pbyp2;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.PRIORITY_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .src0_valid(src0_valid), .src0_addr(src0_addr), .src0_data(src0_data), .src0_ready(r0_ready),
    .src1_valid(src1_valid), .src1_addr(src1_addr), .src1_data(src1_data), .src1_ready(r1_ready),
    .wr_en(r_en), .wr_addr(r_addr), .wr_data(r_data), .last_grant(r_lg)
`ifdef WB_ARB_BYPASS_EN
    , .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .rf_r1_data(rf_r1_data), .rf_r2_data(rf_r2_data),
    .byp_r1_data(byp1), .byp_r2_data(byp2)
`endif
  );

  regfile_wb_arbiter #(.PRIORITY_MODE(1)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .src0_valid(src0_valid), .src0_addr(src0_addr), .src0_data(src0_data), .src0_ready(p0_ready),
    .src1_valid(src1_valid), .src1_addr(src1_addr), .src1_data(src1_data), .src1_ready(p1_ready),
    .wr_en(p_en), .wr_addr(p_addr), .wr_data(p_data), .last_grant(p_lg)
`ifdef WB_ARB_BYPASS_EN
    , .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .rf_r1_data(rf_r1_data), .rf_r2_data(rf_r2_data),
    .byp_r1_data(pbyp1), .byp_r2_data(pbyp2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    src0_valid = 1'b1; src0_addr = 5'd3; src0_data = 32'h0000_0033;
    src1_valid = 1'b1; src1_addr = 5'd7; src1_data = 32'h0000_0077;
`ifdef WB_ARB_BYPASS_EN
    rd1_addr = 5'd9; rd2_addr = 5'd0; rf_r1_data = 32'h0; rf_r2_data = 32'h0000_0077;
`endif

    // Reset held two cycles with both requesters valid.
    cyc();
    chk("rst_rdy0", {31'd0, r0_ready}, 32'd0);
    chk("rst_rdy1", {31'd0, r1_ready}, 32'd0);
    chk("rst_en",   {31'd0, r_en},     32'd0);
    chk("rst_lg",   {31'd0, r_lg},     32'd1);
    chk("rst_prdy0", {31'd0, p0_ready}, 32'd0);
    cyc();
    chk("rst_en2",   {31'd0, r_en}, 32'd0);
    chk("rst_addr",  {27'd0, r_addr}, 32'd0);
    chk("rst_data",  r_data, 32'd0);

    // Release reset: round-robin alternates 0,1,0,1; fixed priority keeps src0.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_rdy0_%0d", i), {31'd0, r0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_rdy1_%0d", i), {31'd0, r1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("pr_rdy0_%0d", i), {31'd0, p0_ready}, 32'd1);
      chk($sformatf("pr_rdy1_%0d", i), {31'd0, p1_ready}, 32'd0);
      cyc();
      chk($sformatf("rr_en_%0d", i),   {31'd0, r_en}, 32'd1);
      chk($sformatf("rr_addr_%0d", i), {27'd0, r_addr}, (i % 2 == 0) ? 32'd3 : 32'd7);
      chk($sformatf("rr_lg_%0d", i),   {31'd0, r_lg}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("pr_addr_%0d", i), {27'd0, p_addr}, 32'd3);
    end

    // src0 drops: fixed-priority finally grants src1.
    src0_valid = 1'b0;
    #1;
    chk("pr_rdy1_drop", {31'd0, p1_ready}, 32'd1);
    chk("rr_rdy1_drop", {31'd0, r1_ready}, 32'd1);
    cyc();
    chk("pr_addr_drop", {27'd0, p_addr}, 32'd7);
    chk("pr_data_drop", p_data, 32'h0000_0077);
    chk("pr_lg_drop",   {31'd0, p_lg}, 32'd1);

    // Idle: wr_en drops, address/data hold.
    src1_valid = 1'b0;
    #1;
    chk("idle_rdy0", {31'd0, r0_ready}, 32'd0);
    chk("idle_rdy1", {31'd0, r1_ready}, 32'd0);
    cyc();
    chk("idle_en",   {31'd0, r_en}, 32'd0);
    chk("idle_addr", {27'd0, r_addr}, 32'd7);
    chk("idle_data", r_data, 32'h0000_0077);
`ifdef WB_ARB_BYPASS_EN
    rd1_addr = 5'd7;
    #1;
    chk("byp_noen", byp1, 32'h0);
    rd1_addr = 5'd9;
`endif

    // Single source.
    src0_valid = 1'b1; src0_addr = 5'd5; src0_data = 32'hDEAD_BEEF;
    #1;
    chk("single_rdy0", {31'd0, r0_ready}, 32'd1);
    cyc();
    chk("single_en",   {31'd0, r_en}, 32'd1);
    chk("single_addr", {27'd0, r_addr}, 32'd5);
    chk("single_data", r_data, 32'hDEAD_BEEF);

    // Zero register: accepted, write suppressed.
    src0_valid = 1'b0;
    src1_valid = 1'b1; src1_addr = 5'd0; src1_data = 32'h0000_1234;
    #1;
    chk("zero_rdy1", {31'd0, r1_ready}, 32'd1);
    cyc();
    chk("zero_en",   {31'd0, r_en}, 32'd0);
    chk("zero_addr", {27'd0, r_addr}, 32'd0);
    chk("zero_data", r_data, 32'h0000_1234);
    chk("zero_lg",   {31'd0, r_lg}, 32'd1);

    // Same destination from both sources: serialized, src1 lands second.
    src0_valid = 1'b1; src0_addr = 5'd9; src0_data = 32'hA5A5_A5A5;
    src1_valid = 1'b1; src1_addr = 5'd9; src1_data = 32'h5A5A_5A5A;
    #1;
    chk("same_rdy0", {31'd0, r0_ready}, 32'd1);
    cyc();
    chk("same_en0",   {31'd0, r_en}, 32'd1);
    chk("same_addr0", {27'd0, r_addr}, 32'd9);
    chk("same_data0", r_data, 32'hA5A5_A5A5);
`ifdef WB_ARB_BYPASS_EN
    chk("byp_r1_hit",  byp1, 32'hA5A5_A5A5);
    chk("byp_r2_zero", byp2, 32'h0000_0077);
`endif
    chk("same_rdy1", {31'd0, r1_ready}, 32'd1);
    cyc();
    chk("same_data1", r_data, 32'h5A5A_5A5A);

    // Reset mid-stream discards staged write.
    rst_n = 1'b0;
    #1;
    chk("mrst_rdy0", {31'd0, r0_ready}, 32'd0);
    chk("mrst_rdy1", {31'd0, r1_ready}, 32'd0);
    cyc();
    chk("mrst_en",   {31'd0, r_en}, 32'd0);
    chk("mrst_addr", {27'd0, r_addr}, 32'd0);
    chk("mrst_lg",   {31'd0, r_lg}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two write-back requesters: src0 (ALU result) and src1 (load unit).
- Arbitrates with valid/ready handshakes and registers the winning write into one output stage.
- The output stage drives the register file's wr_en/wr_addr/wr_data directly.
- Writes to the zero register are accepted from the requester but never forwarded to the register file.

Parameters:
- WIDTH, `WORD: data width of each write.
- ADDR_SPACE, `REG_ADDRESS_SPACE: register address width (5 for 32 registers).
- ZERO_REGISTER, 5'b00000: hardwired-zero register address.
- PRIORITY_MODE, 0: 0 = round-robin; 1 = fixed priority, src0 always wins.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- src0_valid  input  1  ALU write request.
- src0_addr  input  ADDR_SPACE  ALU destination register.
- src0_data  input  WIDTH  ALU write data.
- src0_ready  output  1  ALU request accepted this cycle.
- src1_valid  input  1  load-unit write request.
- src1_addr  input  ADDR_SPACE  load destination register.
- src1_data  input  WIDTH  load write data.
- src1_ready  output  1  load request accepted this cycle.
- wr_en  output  1  register file write enable (registered).
- wr_addr  output  ADDR_SPACE  register file write address (registered).
- wr_data  output  WIDTH  register file write data (registered).
- last_grant  output  1  index of the most recently granted source (registered).

Behaviour:
- Reset: when rst_n=0 at a rising clk edge:
  - wr_en=0, wr_addr=0, wr_data=0.
  - last_grant=1, so src0 wins the first contest.
  - srcN_ready is combinational and depends only on valids and last_grant. It is undefined-free during reset: it is forced to 0 while rst_n=0.
- The output stage never stalls; the register file always accepts. Therefore srcN_ready equals grantN, and a handshake is valid & ready in the same cycle.
- Arbitration (combinational, per cycle):
  - Only one source valid: that source is granted.
  - Both valid, PRIORITY_MODE=0: grant the source != last_grant.
  - Both valid, PRIORITY_MODE=1: grant src0; src1 waits.
  - Neither valid: no grant.
- last_grant updates to the granted index on every grant and holds when there is no grant.
- Latency: a handshake in cycle t produces wr_en/wr_addr/wr_data at cycle t+1. The register file captures the write at the end of cycle t+1.
- Zero register: a granted request with addr==ZERO_REGISTER completes the handshake (ready=1). The stage then loads wr_en=0; wr_addr and wr_data load normally.
- No grant: wr_en=0 next cycle; wr_addr and wr_data hold their previous values.
- Requester protocol: addr and data must stay stable while valid=1 and ready=0. The arbiter does not check this.
- Same destination from both sources in one cycle: the grants serialize. The later grant overwrites, giving round-robin order.
- Reset asserted mid-stream: any pending stage contents are discarded (wr_en=0 next cycle). Requesters must re-present.

Optional Feature:
- Macro: WB_ARB_BYPASS_EN.
- Defined: adds the following ports:
  - inputs rd1_addr, rd2_addr (ADDR_SPACE) and rf_r1_data, rf_r2_data (WIDTH);
  - outputs byp_r1_data, byp_r2_data (WIDTH).
- Defined, combinational bypass: byp_rK_data = wr_data when wr_en=1, wr_addr==rdK_addr and rdK_addr!=ZERO_REGISTER; otherwise rf_rK_data. This hides the one-cycle window before the register file updates.
- Undefined: these ports and the compare logic are absent.

Decomposition:
- Shared package (specs.vh): WORD, REG_ADDRESS_SPACE, ZERO_REGISTER, and source-index constants SRC_ALU=0, SRC_LOAD=1.
- One sub-module: rr_arb2. It holds the two-requester grant logic with the last_grant register and PRIORITY_MODE selection.
- Output stage and bypass logic stay in the top level.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with both valids=1. Expect both ready=0, wr_en=0, last_grant=1. Release: src0 is granted first.
- Single source: src0_valid=1, addr=5, data=0xDEADBEEF at t. Expect src0_ready=1 at t, then wr_en=1, wr_addr=5, wr_data=0xDEADBEEF at t+1.
- Contention, PRIORITY_MODE=0: both valid for 4 cycles, src0 addr=3, src1 addr=7. Expect grants 0,1,0,1 and wr_addr 3,7,3,7 one cycle later.
- Contention, PRIORITY_MODE=1: both valid for 3 cycles. Expect src0_ready=1 every cycle, src1_ready=0, and src1 granted the cycle src0_valid drops.
- Zero register: src1 valid, addr=0, data=0x1234. Expect src1_ready=1, then wr_en=0 the next cycle.
- Bypass (WB_ARB_BYPASS_EN defined):
  - While wr_en=1, wr_addr=9, wr_data=0xA5A5A5A5, drive rd1_addr=9 and rf_r1_data=0. Expect byp_r1_data=0xA5A5A5A5.
  - Drive rd2_addr=0. Expect byp_r2_data=rf_r2_data.
